cpu_muldiv: RTL and testbench
=============================

Name: cpu_muldiv

Overview:
Parametrised iterative RV M-extension execution unit. It replaces the fixed DSP multiplier and the separate divider with one multi-cycle datapath covering all eight M ops. The width and the bits retired per cycle are configurable. The core drives operands and op through a valid/ready request, then waits on a result valid/ready handshake, so it can stall or flush cleanly.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
BITS_PER_CYCLE, 1, bits retired per iteration; legal values 1, 2 or 4; must divide XLEN
ITER, XLEN/BITS_PER_CYCLE, derived localparam; number of iterations

Ports:
clk_i  in  1  clock; all logic on rising edge
rstn_i  in  1  reset; synchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept a request
op_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  XLEN  rs1 value
b_i  in  XLEN  rs2 value
kill_i  in  1  abort the in-flight op (pipeline flush)
res_valid_o  out  1  result available
res_ready_i  in  1  consumer takes the result
res_o  out  XLEN  result

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rstn_i low at an edge) forces IDLE; res_valid_o=0, res_o=0, req_ready_o=1 in the following cycle. Reset overrides every other input.
- req_ready_o = (state==IDLE). Accept = req_valid_i & req_ready_o. On accept, op/a/b are latched; inputs are don't-care afterwards.
- Signed handling: signed operands (MULH both, MULHSU a only, DIV/REM both) are converted to magnitude on accept. Result sign: product = sa^sb; quotient = sa^sb; remainder = sa.
- Normal path, accept at cycle 0:
  - CALC runs cycles 1..ITER.
  - Multiply: radix-2 shift-add over a 2*XLEN accumulator, BITS_PER_CYCLE steps per cycle.
  - Divide: restoring shift-subtract, BITS_PER_CYCLE steps per cycle.
  - FIX at cycle ITER+1: applies the sign negation and the low/high or quotient/remainder select.
  - DONE from cycle ITER+2, so res_valid_o=1 there. Default case (XLEN=32, BITS_PER_CYCLE=1): res_valid_o rises at cycle 34.
- Special cases are resolved on accept and go directly to DONE, so res_valid_o rises at cycle 1:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow, a=MIN and b=-1: DIV gives MIN; REM gives 0.
- DONE: res_o and res_valid_o are held stable until res_valid_o & res_ready_i. After that handshake the state is IDLE next cycle, and req_ready_o=1 that cycle. No back-to-back accept in the handshake cycle.
- res_o is registered. It changes only on the FIX→DONE or special→DONE transition and is otherwise stable.
- kill_i in CALC, FIX or DONE: the state is IDLE next cycle and res_valid_o=0. kill_i in IDLE is ignored. kill_i together with accept in IDLE: the accept wins and kill_i is ignored.
- MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits of the correctly signed 2*XLEN product.

Decomposition:
- Package cpu_muldiv_pkg holds: the op encoding typedef (funct3 values above, as an enum), the state enum, and helpers is_div(op), is_signed_a(op), is_signed_b(op).
- Sub-module cpu_muldiv_step: one combinational radix-2 step, in mul or div mode, parametrised by XLEN. It is instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → res_o=0xFFFFFFEB; res_valid_o rises at cycle 34.
- High products with a=b=0xFFFFFFFF: MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF.
- Special cases, each with res_valid_o at cycle 1:
  - DIVU a=5, b=0 → 0xFFFFFFFF.
  - REMU a=5, b=0 → 5.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - REM a=0x80000000, b=0xFFFFFFFF → 0.
- Backpressure and kill:
  - Hold res_ready_i low 5 cycles in DONE → res_o stable, req_ready_o=0 throughout.
  - Assert kill_i at cycle 10 of a DIV → IDLE at cycle 11, no res_valid_o.
  - A following MULHU 3×5 → 0.
- BITS_PER_CYCLE=4 build: DIVU 100/7 → 14 with res_valid_o at cycle 10; REMU 100/7 → 2.
- Reset mid-CALC → IDLE next cycle, res_valid_o=0, res_o=0.

Source files
------------

// File: rtl/cpu_muldiv_pkg.sv
// rtl/cpu_muldiv_pkg.sv - shared types and op-decode helpers for the M-extension unit
package cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/cpu_muldiv_step.sv
// rtl/cpu_muldiv_step.sv - one combinational radix-2 shift-add / restoring-divide step
module cpu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opd_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // mul: acc = {partial product, remaining multiplier bits}
    // div: acc = {partial remainder, dividend bits shifting into quotient bits}
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
        rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        diff   = rem_sh - {1'b0, opd_i};
        if (!div_i) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cpu_muldiv.sv
// rtl/cpu_muldiv.sv - iterative multi-cycle RV M-extension multiply/divide unit
module cpu_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*XLEN-1:0]  acc_q;
    logic [XLEN-1:0]    opd_q;
    op_e                op_q;
    logic               neg_q;
    logic [XLEN-1:0]    res_q;

    op_e                op_in;
    logic               accept;
    logic               sa, sb;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               div_zero, ovf, special;
    logic [XLEN-1:0]    special_res;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quo, rem, fix_res;

    always_comb begin
        op_in    = op_e'(op_i);
        accept   = req_valid_i && (state_q == S_IDLE);
        sa       = is_signed_a(op_in) && a_i[XLEN-1];
        sb       = is_signed_b(op_in) && b_i[XLEN-1];
        a_mag    = sa ? -a_i : a_i;
        b_mag    = sb ? -b_i : b_i;
        div_zero = is_div(op_in) && (b_i == '0);
        ovf      = (op_in == OP_DIV || op_in == OP_REM) && (a_i == MIN_VAL) && (b_i == '1);
        special  = div_zero || ovf;
        // op_in[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = op_in[1] ? a_i : '1;
        end else begin
            special_res = op_in[1] ? '0 : MIN_VAL;
        end
    end

    logic [2*XLEN-1:0] chain [0:BITS_PER_CYCLE];
    assign chain[0] = acc_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        cpu_muldiv_step #(.XLEN(XLEN)) u_step (
            .div_i (is_div(op_q)),
            .acc_i (chain[g]),
            .opd_i (opd_q),
            .acc_o (chain[g+1])
        );
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo;
            default:                       fix_res = rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill_i)                                state_d = S_IDLE;
                else if (cnt_q == CNT_W'(ITER - 1))        state_d = S_FIX;
            end
            S_FIX:  state_d = kill_i ? S_IDLE : S_DONE;
            S_DONE: if (kill_i || res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        res_valid_o = (state_q == S_DONE);
        res_o       = res_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            opd_q <= '0;
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
            res_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        cnt_q <= '0;
                        if (special) begin
                            res_q <= special_res;
                        end else if (is_div(op_in)) begin
                            acc_q <= {{XLEN{1'b0}}, a_mag};
                            opd_q <= b_mag;
                            neg_q <= op_in[1] ? sa : (sa ^ sb);
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, b_mag};
                            opd_q <= a_mag;
                            neg_q <= sa ^ sb;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= chain[BITS_PER_CYCLE];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    if (!kill_i) res_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_muldiv.sv
// tb/tb_cpu_muldiv.sv - directed self-checking bench for cpu_muldiv (1 and 4 bits per cycle)
module tb_cpu_muldiv;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rv = 1'b0, kill = 1'b0, rr = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] a = '0, b = '0;
    logic        rq, vv;
    logic [31:0] res;
    logic        rv4 = 1'b0, kill4 = 1'b0, rr4 = 1'b0;
    logic [2:0]  op4 = 3'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        rq4, vv4;
    logic [31:0] res4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv), .req_ready_o(rq), .op_i(op),
        .a_i(a), .b_i(b), .kill_i(kill), .res_valid_o(vv), .res_ready_i(rr), .res_o(res)
    );

    cpu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv4), .req_ready_o(rq4), .op_i(op4),
        .a_i(a4), .b_i(b4), .kill_i(kill4), .res_valid_o(vv4), .res_ready_i(rr4), .res_o(res4)
    );

    task automatic issue(input bit w4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        if (w4) begin rv4 = 1'b1; op4 = o; a4 = x; b4 = y; end
        else    begin rv  = 1'b1; op  = o; a  = x; b  = y; end
        @(posedge clk);
        #1;
        rv = 1'b0; rv4 = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        op4 = 3'($urandom); a4 = $urandom; b4 = $urandom;
    endtask

    // lat counts negedges after the accepting edge; 200 marks an expired wait
    task automatic wait_valid(input bit w4, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(w4 ? vv4 : vv) && lat < 200);
    endtask

    task automatic take(input bit w4);
        if (w4) rr4 = 1'b1; else rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0; rr4 = 1'b0;
    endtask

    task automatic run(input bit w4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat);
        issue(w4, o, x, y);
        wait_valid(w4, lat);
        r = w4 ? res4 : res;
        take(w4);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_chk++; if (rq !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %b want 1", rq); end
        n_chk++; if (vv !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b want 0", vv); end
        n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", res); end
    endtask

    task automatic test_mul;
        logic [31:0] r; int lat;
        run(0, MUL, 32'd7, 32'hFFFFFFFD, r, lat);
        n_chk++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_res got %h want ffffffeb", r); end
        n_chk++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency got %0d want 34", lat); end
    endtask

    task automatic test_mul_high;
        logic [31:0] r; int lat;
        run(0, MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        n_chk++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL mulh_res got %h want 00000000", r); end
        run(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        n_chk++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_res got %h want fffffffe", r); end
        run(0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_res got %h want ffffffff", r); end
    endtask

    task automatic test_div;
        logic [31:0] r; int lat;
        run(0, DIV, 32'hFFFFFFF9, 32'd2, r, lat);
        n_chk++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_res got %h want fffffffd", r); end
        n_chk++; if (lat != 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        run(0, REM, 32'hFFFFFFF9, 32'd2, r, lat);
        n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_res got %h want ffffffff", r); end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{DIVU, REMU, DIV, REM};
        logic [31:0] xs  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r; int lat;
        for (int i = 0; i < 4; i++) begin
            run(0, ops[i], xs[i], ys[i], r, lat);
            n_chk++; if (r !== exp[i]) begin n_fail++; $display("FAIL special_res[%0d] got %h want %h", i, r, exp[i]); end
            n_chk++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        issue(0, MUL, 32'd7, 32'hFFFFFFFD);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL bp_res[%0d] got %h want ffffffeb", i, res); end
            n_chk++; if (vv !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, vv); end
            n_chk++; if (rq !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, rq); end
            if (i < 4) @(negedge clk);
        end
        take(0);
        @(negedge clk);
        n_chk++; if (rq !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", rq); end
        n_chk++; if (vv !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid got %b want 0", vv); end
    endtask

    task automatic test_kill;
        logic [31:0] r; int lat; int seen;
        issue(0, DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        n_chk++; if (rq !== 1'b1) begin n_fail++; $display("FAIL kill_ready got %b want 1", rq); end
        n_chk++; if (vv !== 1'b0) begin n_fail++; $display("FAIL kill_valid got %b want 0", vv); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (vv) seen++; end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL kill_no_result got %0d valid cycles want 0", seen); end
        run(0, MULHU, 32'd3, 32'd5, r, lat);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL post_kill_mulhu got %h want 0", r); end
        n_chk++; if (lat != 34) begin n_fail++; $display("FAIL post_kill_latency got %0d want 34", lat); end
        kill = 1'b1;
        issue(0, MUL, 32'd6, 32'd7);
        kill = 1'b0;
        wait_valid(0, lat);
        n_chk++; if (res !== 32'd42) begin n_fail++; $display("FAIL kill_accept_res got %h want 0000002a", res); end
        n_chk++; if (lat != 34) begin n_fail++; $display("FAIL kill_accept_latency got %0d want 34", lat); end
        take(0);
    endtask

    task automatic test_bpc4;
        logic [31:0] r; int lat;
        run(1, DIVU, 32'd100, 32'd7, r, lat);
        n_chk++; if (r !== 32'd14) begin n_fail++; $display("FAIL bpc4_divu got %h want 0000000e", r); end
        n_chk++; if (lat != 10) begin n_fail++; $display("FAIL bpc4_latency got %0d want 10", lat); end
        run(1, REMU, 32'd100, 32'd7, r, lat);
        n_chk++; if (r !== 32'd2) begin n_fail++; $display("FAIL bpc4_remu got %h want 00000002", r); end
        run(1, MUL, 32'd7, 32'hFFFFFFFD, r, lat);
        n_chk++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL bpc4_mul got %h want ffffffeb", r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int lat;
        run(0, MUL, 32'd3, 32'd4, r, lat);
        n_chk++; if (res !== 32'd12) begin n_fail++; $display("FAIL pre_reset_res got %h want 0000000c", res); end
        issue(0, DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_chk++; if (rq !== 1'b1)   begin n_fail++; $display("FAIL midreset_ready got %b want 1", rq); end
        n_chk++; if (vv !== 1'b0)   begin n_fail++; $display("FAIL midreset_valid got %b want 0", vv); end
        n_chk++; if (res !== 32'h0) begin n_fail++; $display("FAIL midreset_res got %h want 0", res); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_backpressure();
        test_kill();
        test_bpc4();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
